recurrence_seq_gen: RTL

//  Parametrised third-order linear-recurrence generator: a(n+3) = t1*a(n+2) + t2*a(n+1) + t3*a(n), with tap mask t in {0,1}^3.

---
 rtl/recurrence_seq_gen_pkg.sv | 45 ++++
 rtl/recurrence_seq_gen_if.sv | 13 +
 rtl/recurrence_seq_gen_tap_adder.sv | 21 ++
 rtl/recurrence_seq_gen.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/recurrence_seq_gen_pkg.sv
// Shared types and preset table for the third-order recurrence generator.
// Taps are packed {t3,t2,t1}: bit 0 weights a(n+2), bit 2 weights a(n).
package recurrence_seq_pkg;

    typedef enum logic [2:0] {
        MODE_CUSTOM     = 3'd0,
        MODE_PADOVAN    = 3'd1,
        MODE_PERRIN     = 3'd2,
        MODE_FIBONACCI  = 3'd3,
        MODE_TRIBONACCI = 3'd4,
        MODE_NARAYANA   = 3'd5
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [2:0] taps;
        logic [1:0] s2;
        logic [1:0] s1;
        logic [1:0] s0;
    } preset_t;

    function automatic logic mode_legal(input logic [2:0] m);
        return (m <= 3'd5);
    endfunction

    function automatic preset_t preset_lookup(input logic [2:0] m);
        preset_t p;
        p = '0;
        case (m)
            MODE_PADOVAN:    p = '{taps: 3'b110, s2: 2'd1, s1: 2'd1, s0: 2'd1};
            MODE_PERRIN:     p = '{taps: 3'b110, s2: 2'd2, s1: 2'd0, s0: 2'd3};
            MODE_FIBONACCI:  p = '{taps: 3'b011, s2: 2'd1, s1: 2'd1, s0: 2'd0};
            MODE_TRIBONACCI: p = '{taps: 3'b111, s2: 2'd1, s1: 2'd0, s0: 2'd0};
            MODE_NARAYANA:   p = '{taps: 3'b101, s2: 2'd1, s1: 2'd1, s0: 2'd1};
            default:         p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/recurrence_seq_gen_if.sv
// Output term stream: valid/ready with the term value and its index.
interface recurrence_seq_gen_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) ();
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] term;
    logic [CNT_W-1:0] index;

    modport master (output out_valid, output term, output index, input out_ready);
    modport slave  (input out_valid, input term, input index, output out_ready);
endinterface

// File: rtl/recurrence_seq_gen_tap_adder.sv
// Tap-masked sum of the three window entries with two guard bits for overflow.
module seq_tap_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a2,
    input  logic [2:0]       taps,
    output logic [WIDTH+1:0] sum,
    output logic             ovf
);
    logic [WIDTH+1:0] p0, p1, p2;

    always_comb begin
        p0  = taps[2] ? {2'b00, a0} : '0;
        p1  = taps[1] ? {2'b00, a1} : '0;
        p2  = taps[0] ? {2'b00, a2} : '0;
        sum = p0 + p1 + p2;
        ovf = |sum[WIDTH+1:WIDTH];
    end
endmodule

// File: rtl/recurrence_seq_gen.sv
// Third-order linear-recurrence term generator on a valid/ready stream,
// with preset/custom taps, optional term limit and clean stop on overflow.
module recurrence_seq_gen
    import recurrence_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           mode,
    input  logic [2:0]           taps,
    input  logic [WIDTH-1:0]     seed0,
    input  logic [WIDTH-1:0]     seed1,
    input  logic [WIDTH-1:0]     seed2,
    input  logic [CNT_W-1:0]     len,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf,
    output logic                 err,
    recurrence_seq_gen_if.master strm
);
    state_e           state_q;
    logic [WIDTH-1:0] w0_q, w1_q, w2_q;
    logic [1:0]       avail_q;
    logic [CNT_W-1:0] index_q, len_q;
    logic [2:0]       taps_q;
    logic             valid_q, busy_q, done_q, ovf_q, err_q;

    logic [WIDTH+1:0] sum;
    logic             add_ovf;
    logic             nxt_fits;
    logic             hs, stop_len, stop_ovf, stop_wrap, stop_any;
    preset_t          ps;
    logic [WIDTH-1:0] s0_d, s1_d, s2_d;
    logic [2:0]       taps_d;

    seq_tap_adder #(.WIDTH(WIDTH)) u_add (
        .a0   (w0_q),
        .a1   (w1_q),
        .a2   (w2_q),
        .taps (taps_q),
        .sum  (sum),
        .ovf  (add_ovf)
    );

    always_comb begin
        ps       = preset_lookup(mode);
        nxt_fits = !add_ovf && (sum[WIDTH+1:WIDTH] == 2'b00);
        hs       = valid_q && strm.out_ready;
        stop_len  = (len_q != '0) && (index_q == len_q - CNT_W'(1));
        stop_wrap = (len_q == '0) && (&index_q);
        // avail==1 can only happen once an overflowed term has been dropped
        stop_ovf  = (avail_q == 2'd1);
        stop_any  = stop_len || stop_wrap || stop_ovf;
        if (mode == MODE_CUSTOM) begin
            s0_d   = seed0;
            s1_d   = seed1;
            s2_d   = seed2;
            taps_d = taps;
        end else begin
            s0_d   = {{(WIDTH-2){1'b0}}, ps.s0};
            s1_d   = {{(WIDTH-2){1'b0}}, ps.s1};
            s2_d   = {{(WIDTH-2){1'b0}}, ps.s2};
            taps_d = ps.taps;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            w0_q    <= '0;
            w1_q    <= '0;
            w2_q    <= '0;
            avail_q <= '0;
            index_q <= '0;
            len_q   <= '0;
            taps_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        if (mode_legal(mode)) begin
                            state_q <= RUN;
                            w0_q    <= s0_d;
                            w1_q    <= s1_d;
                            w2_q    <= s2_d;
                            taps_q  <= taps_d;
                            len_q   <= len;
                            avail_q <= 2'd3;
                            index_q <= '0;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                            ovf_q   <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (hs) begin
                        if (stop_any) begin
                            // a satisfied length limit outranks a pending overflow
                            state_q <= DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            ovf_q   <= stop_ovf && !stop_len && !stop_wrap;
                        end else begin
                            w0_q    <= w1_q;
                            w1_q    <= w2_q;
                            index_q <= index_q + CNT_W'(1);
                            if (avail_q == 2'd3 && nxt_fits) begin
                                w2_q <= sum[WIDTH-1:0];
                            end else begin
                                avail_q <= avail_q - 2'd1;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign strm.out_valid = valid_q;
    assign strm.term      = w0_q;
    assign strm.index     = index_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign ovf            = ovf_q;
    assign err            = err_q;

endmodule
